wave_param_loader: RTL
======================

// Module: wave_param_loader
// PURPOSE
// - Upstream stage of the triangle/sawtooth/square waveform generator top.
// - Receives writes from chip pins: an 8-bit data bus, a 2-bit address and a write-enable level.
// - Holds the writes in shadow registers and drives phase_i, amplitude_i and next_data_strobe_i of the generator.
// - Applies new settings atomically on sample boundaries, so a waveform never mixes old and new settings.
// PARAMETERS
// - N_FRAC       7  fractional bits; data words are N_FRAC+1 bits, signed
// - DIV_W        8  width of the sample-rate divider register and counter
// - SYNC_STAGES  2  flops in the cfg_we_i synchronizer (minimum 2)
// PORTS
// - clk_i               in   1         single system clock
// - rst_i               in   1         synchronous, active-high reset
// - cfg_data_i          in   N_FRAC+1  write data from pins
// - cfg_addr_i          in   2         register address from pins
// - cfg_we_i            in   1         write-enable from pins, asynchronous; a rising edge commits a write
// - cfg_ack_o           out  1         one-cycle pulse when a shadow register has been written
// - phase_o             out  N_FRAC+1  signed active phase increment, to phase_i
// - amplitude_o         out  N_FRAC+1  signed active amplitude/threshold, to amplitude_i
// - wave_sel_o          out  2         active waveform select, to the downstream output mux
// - next_data_strobe_o  out  1         one-cycle sample strobe, to next_data_strobe_i
// BEHAVIOUR
// - Reset values (clears all flops, including the synchronizer):
//   - shadow and active phase, amplitude, divider, wave_sel = 0; enable = 0
//   - next_data_strobe_o = 0, cfg_ack_o = 0, divider count = 0
// - Write path:
//   - cfg_we_i passes through SYNC_STAGES flops, then one more flop for edge detection.
//   - A rising edge is detected SYNC_STAGES+1 clocks after the pin edge.
//   - cfg_addr_i and cfg_data_i are sampled in the detect cycle; the host holds them stable for >= SYNC_STAGES+3 clocks.
//   - The shadow register is written at the end of the detect cycle. cfg_ack_o is high for the next cycle only.
//   - A falling edge or a held-high level produces no write.
// - Address map:
//   - 0 = phase, 1 = amplitude, 2 = divider (unsigned)
//   - 3 = control: bit0 enable, bits[2:1] wave_sel; other bits are ignored
// - Enable takes effect from the shadow value immediately; it is not double-buffered.
// - Divider:
//   - While enable = 1, the counter runs 0..div_active.
//   - When count == div_active: next_data_strobe_o = 1 in the next cycle, and the count returns to 0.
//   - Strobe period = div_active+1 clocks. div_active = 0 gives a strobe every clock.
// - Apply:
//   - Active phase, amplitude, wave_sel and div_active load from shadow in the wrap cycle, so they are valid when the strobe is high.
//   - While enable = 0: the counter is held at 0, no strobes are issued, and active registers track shadow every cycle.
// - Enable 0->1: the first strobe is issued div_active+1 clocks after the enable takes effect.
// - Enable 1->0: the counter clears at once; a strobe already registered for that cycle still completes.
// - Write in the same cycle as a wrap: the apply uses the pre-write shadow value; the new value applies at the following wrap.
// - Writing a divider smaller than the current count is safe, because div_active changes only at a wrap.
// - Reset mid-operation clears all state on the next edge, drops any in-flight write (no ack) and gives strobe = 0 in the following cycle.
// - All outputs are registered; there are no combinational paths from inputs to outputs.
// STRUCTURE
// - Shared header wave_defs.vh (include-guarded):
//   - address constants ADDR_PHASE/ADDR_AMPL/ADDR_DIV/ADDR_CTRL
//   - CTRL_EN_BIT and wave_sel encodings: 0 sawtooth, 1 triangle, 2 square, 3 reserved
// - Sub-module sync_edge_detect #(SYNC_STAGES): synchronizes cfg_we_i and outputs a one-cycle rise pulse. It is reusable for other pin inputs.
// - The top-level file holds the shadow regs, active regs and divider counter.
// TESTING
// - Reset: assert rst_i for 2 clocks -> all outputs 0, no strobe for 20 clocks.
// - Write timing, SYNC_STAGES=2: write addr0=0x10 -> cfg_ack_o pulses exactly once, 4 clocks after the pin edge; phase_o stays 0 while enable=0 until the shadow updates, then reads 0x10.
// - Divider: div=3, ctrl=0x01 -> strobes every 4 clocks; first strobe 4 clocks after enable; div=0 -> a strobe every clock.
// - Atomic apply: enabled with div=9, write amplitude 0x40 mid-period -> amplitude_o changes only in the strobe cycle, never between strobes.
// - Collision: write phase=0x05 timed so detect coincides with a wrap -> old phase is applied at that strobe, 0x05 at the next strobe.
// - Reset mid-write: assert rst_i between the pin edge and ack -> no cfg_ack_o, shadow stays 0, strobes stop.

Source files
------------

// File: rtl/wave_param_loader_pkg.sv
// Shared constants for the waveform parameter loader: register map,
// control-word layout and waveform select encodings.
package wave_param_loader_pkg;

    localparam int DEF_N_FRAC      = 7;
    localparam int DEF_DIV_W       = 8;
    localparam int DEF_SYNC_STAGES = 2;

    localparam logic [1:0] ADDR_PHASE = 2'd0;
    localparam logic [1:0] ADDR_AMPL  = 2'd1;
    localparam logic [1:0] ADDR_DIV   = 2'd2;
    localparam logic [1:0] ADDR_CTRL  = 2'd3;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_SEL_LSB = 1;
    localparam int CTRL_SEL_MSB = 2;

    typedef enum logic [1:0] {
        WAVE_SAW  = 2'd0,
        WAVE_TRI  = 2'd1,
        WAVE_SQR  = 2'd2,
        WAVE_RSVD = 2'd3
    } wave_sel_e;

endpackage

// File: rtl/wave_param_loader_sync_edge_detect.sv
// Synchronizes an asynchronous pin and emits a registered one-cycle pulse
// on each rising edge. Reusable for any pin input.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;

    // Synchronizer chain, previous-level flop and registered rise pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync <= {SYNC_STAGES{1'b0}};
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_i};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign rise_o = r_rise;

endmodule

// File: rtl/wave_param_loader.sv
// Pin-driven shadow registers for the waveform generator; settings move to
// the active set only on sample boundaries so a period never mixes values.
module wave_param_loader
    import wave_param_loader_pkg::*;
#(
    parameter int N_FRAC      = DEF_N_FRAC,
    parameter int DIV_W       = DEF_DIV_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_FRAC:0]   cfg_data_i,
    input  logic [1:0]        cfg_addr_i,
    input  logic              cfg_we_i,
    output logic              cfg_ack_o,
    output logic [N_FRAC:0]   phase_o,
    output logic [N_FRAC:0]   amplitude_o,
    output logic [1:0]        wave_sel_o,
    output logic              next_data_strobe_o
);

    logic              w_rise;
    logic              w_wrap;
    logic              w_load;

    logic [N_FRAC:0]   r_sh_phase;
    logic [N_FRAC:0]   r_sh_ampl;
    logic [DIV_W-1:0]  r_sh_div;
    logic              r_sh_en;
    wave_sel_e         r_sh_sel;
    logic              r_ack;

    logic [N_FRAC:0]   r_act_phase;
    logic [N_FRAC:0]   r_act_ampl;
    logic [DIV_W-1:0]  r_act_div;
    wave_sel_e         r_act_sel;
    logic [DIV_W-1:0]  r_cnt;
    logic              r_strobe;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_we_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (cfg_we_i),
        .rise_o  (w_rise)
    );

    // Host writes land in the shadow set; ack follows one cycle later
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sh_phase <= {(N_FRAC+1){1'b0}};
            r_sh_ampl  <= {(N_FRAC+1){1'b0}};
            r_sh_div   <= {DIV_W{1'b0}};
            r_sh_en    <= 1'b0;
            r_sh_sel   <= WAVE_SAW;
            r_ack      <= 1'b0;
        end else begin
            r_ack <= w_rise;
            if (w_rise) begin
                case (cfg_addr_i)
                    ADDR_PHASE: r_sh_phase <= cfg_data_i;
                    ADDR_AMPL:  r_sh_ampl  <= cfg_data_i;
                    ADDR_DIV:   r_sh_div   <= DIV_W'(cfg_data_i);
                    ADDR_CTRL: begin
                        r_sh_en  <= cfg_data_i[CTRL_EN_BIT];
                        r_sh_sel <= wave_sel_e'(cfg_data_i[CTRL_SEL_MSB:CTRL_SEL_LSB]);
                    end
                    default: r_sh_en <= r_sh_en;
                endcase
            end else begin
                r_sh_en <= r_sh_en;
            end
        end
    end

    // Enable is not double-buffered; the divider limit changes only at a wrap
    assign w_wrap = (r_cnt == r_act_div);
    assign w_load = ~r_sh_en | w_wrap;

    // Sample-rate divider, strobe generation and atomic apply of the active set
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt       <= {DIV_W{1'b0}};
            r_strobe    <= 1'b0;
            r_act_phase <= {(N_FRAC+1){1'b0}};
            r_act_ampl  <= {(N_FRAC+1){1'b0}};
            r_act_div   <= {DIV_W{1'b0}};
            r_act_sel   <= WAVE_SAW;
        end else begin
            if (!r_sh_en) begin
                r_cnt    <= {DIV_W{1'b0}};
                r_strobe <= 1'b0;
            end else if (w_wrap) begin
                r_cnt    <= {DIV_W{1'b0}};
                r_strobe <= 1'b1;
            end else begin
                r_cnt    <= r_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
                r_strobe <= 1'b0;
            end
            if (w_load) begin
                r_act_phase <= r_sh_phase;
                r_act_ampl  <= r_sh_ampl;
                r_act_div   <= r_sh_div;
                r_act_sel   <= r_sh_sel;
            end else begin
                r_act_sel   <= r_act_sel;
            end
        end
    end

    assign cfg_ack_o          = r_ack;
    assign phase_o            = r_act_phase;
    assign amplitude_o        = r_act_ampl;
    assign wave_sel_o         = r_act_sel;
    assign next_data_strobe_o = r_strobe;

endmodule
